// File: rtl/addsub_arbiter_pkg.sv
// Shared constants and helpers for the add/subtract datapath and its arbiter.
//   WORD_W          : datapath width (64)
//   OP_ADD / OP_SUB : requester operation encoding
//   CC_ZF/CC_SF/CC_OF : bit positions of the Y86 condition codes in a cc vector
//   cc_flags()      : condition codes from operands, result and operation
package addsub_arbiter_pkg;

  localparam int WORD_W = 64;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int CC_W  = 3;
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  typedef enum logic {
    RESP_EMPTY = 1'b0,
    RESP_FULL  = 1'b1
  } resp_state_e;

  // Overflow is judged against the raw operand B: for a subtract the signs must
  // differ, for an add they must match, and in both cases the result sign must
  // disagree with A.
  function automatic logic [CC_W-1:0] cc_flags(
    input logic signed [WORD_W-1:0] a,
    input logic signed [WORD_W-1:0] b,
    input logic signed [WORD_W-1:0] r,
    input logic                     op
  );
    logic [CC_W-1:0] cc;
    logic            same_sign;
    same_sign = (a[WORD_W-1] == b[WORD_W-1]);
    cc        = '0;
    cc[CC_ZF] = (r == '0);
    cc[CC_SF] = r[WORD_W-1];
    cc[CC_OF] = ((op == OP_SUB) ? !same_sign : same_sign) && (r[WORD_W-1] != a[WORD_W-1]);
    return cc;
  endfunction

endpackage

// File: rtl/addsub_arbiter_if.sv
// Request/response bus of the shared add/subtract unit.
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_in1/req_in2     : 64-bit operand slices, requester i at [64i+63:64i]
//   req_op              : per-requester op (0 add, 1 subtract)
//   resp_*              : single-entry response with valid/ready handshake
// master = requesters and response consumer, slave = the arbitrated unit.
interface addsub_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
);
  import addsub_arbiter_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [WORD_W*NREQ-1:0] req_in1;
  logic [WORD_W*NREQ-1:0] req_in2;
  logic [NREQ-1:0]        req_op;
  logic [NREQ-1:0]        req_ready;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [IDW-1:0]         resp_id;
  logic [WORD_W-1:0]      resp_out;
  logic                   resp_zf;
  logic                   resp_sf;
  logic                   resp_of;

  modport master (
    output req_valid, req_in1, req_in2, req_op, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_out, resp_zf, resp_sf, resp_of
  );

  modport slave (
    input  req_valid, req_in1, req_in2, req_op, resp_ready,
    output req_ready, resp_valid, resp_id, resp_out, resp_zf, resp_sf, resp_of
  );

endinterface

// File: rtl/addsub_arbiter_alu.sv
// Combinational 64-bit add/subtract with Y86 condition codes.
//   a, b : operands
//   op   : OP_ADD -> a+b, OP_SUB -> a-b
//   r    : result modulo 2^64 (carry-out dropped)
//   cc   : {ZF,SF,OF} at CC_* positions
module addsub64
  import addsub_arbiter_pkg::*;
(
  input  logic signed [WORD_W-1:0] a,
  input  logic signed [WORD_W-1:0] b,
  input  logic                     op,
  output logic signed [WORD_W-1:0] r,
  output logic        [CC_W-1:0]   cc
);

  logic signed [WORD_W-1:0] b_x;

  // Subtract as A + ~B + 1 so one adder serves both operations.
  assign b_x = b ^ {WORD_W{op}};
  assign r   = a + b_x + WORD_W'(op);
  assign cc  = cc_flags(a, b, r, op);

endmodule

// File: rtl/addsub_arbiter_rr.sv
// Round-robin arbiter with a rotating priority pointer.
//   clk, rst  : clock, async active-high reset (pointer -> 0)
//   req       : request vector
//   en        : grants allowed this cycle
//   grant     : one-hot grant (zero when en low or no request)
//   grant_idx : index of the winner (valid when grant_vld)
//   grant_vld : a grant is issued this cycle
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx,
  output logic            grant_vld
);

  logic [PW-1:0] ptr_p1;
  logic [PW-1:0] pick;
  logic          found;
  int            j;

  // Search upward from the pointer, wrapping, and keep the first hit.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_p1) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        pick  = PW'(j);
      end
    end
  end

  assign grant_vld = en && found;
  assign grant_idx = pick;
  assign grant     = grant_vld ? (NREQ'(1) << pick) : '0;

  // Pointer moves just past the winner; holds when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_p1 <= '0;
    end else if (grant_vld) begin
      ptr_p1 <= (pick == PW'(NREQ - 1)) ? '0 : pick + 1'b1;
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Shares one 64-bit add/subtract datapath among NREQ requesters. A round-robin
// arbiter picks one request per cycle; the result, winner ID and condition
// codes land in a single-entry response register one cycle after acceptance.
//   clk, rst : clock, async active-high reset
//   bus      : addsub_arbiter_if.slave (request vectors in, response out)
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  addsub_arbiter_if.slave      bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic                     can_issue;
  logic [NREQ-1:0]          grant;
  logic [PW-1:0]            gidx;
  logic                     transfer;
  logic signed [WORD_W-1:0] a_p0;
  logic signed [WORD_W-1:0] b_p0;
  logic                     op_p0;
  logic signed [WORD_W-1:0] r_p0;
  logic [CC_W-1:0]          cc_p0;

  resp_state_e              state_p1;
  resp_state_e              state_nxt;
  logic [IDW-1:0]           id_p1;
  logic [WORD_W-1:0]        out_p1;
  logic [CC_W-1:0]          cc_p1;

  // ---- stage 0: arbitration and shared datapath ----
  // A slot frees up in the same cycle the consumer drains it, so resp_ready
  // feeds straight through to req_ready.
  assign can_issue = (state_p1 == RESP_EMPTY) || bus.resp_ready;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_valid),
    .en        (can_issue),
    .grant     (grant),
    .grant_idx (gidx),
    .grant_vld (transfer)
  );

  assign bus.req_ready = grant;

  assign a_p0  = bus.req_in1[int'(gidx)*WORD_W +: WORD_W];
  assign b_p0  = bus.req_in2[int'(gidx)*WORD_W +: WORD_W];
  assign op_p0 = bus.req_op[gidx];

  addsub64 u_alu (
    .a  (a_p0),
    .b  (b_p0),
    .op (op_p0),
    .r  (r_p0),
    .cc (cc_p0)
  );

  // ---- stage 1: response register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_p1 <= RESP_EMPTY;
    else     state_p1 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      RESP_EMPTY: if (transfer) state_nxt = RESP_FULL;
      RESP_FULL:  if (bus.resp_ready && !transfer) state_nxt = RESP_EMPTY;
      default:    state_nxt = RESP_EMPTY;
    endcase
  end

  always_comb begin
    bus.resp_valid = (state_p1 == RESP_FULL);
  end

  // Transfers only happen when the slot is free or draining, so loading on a
  // transfer never overwrites an unconsumed response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_p1  <= '0;
      out_p1 <= '0;
      cc_p1  <= '0;
    end else if (transfer) begin
      id_p1  <= IDW'(gidx);
      out_p1 <= r_p0;
      cc_p1  <= cc_p0;
    end
  end

  assign bus.resp_id  = id_p1;
  assign bus.resp_out = out_p1;
  assign bus.resp_zf  = cc_p1[CC_ZF];
  assign bus.resp_sf  = cc_p1[CC_SF];
  assign bus.resp_of  = cc_p1[CC_OF];

endmodule

// File: tb/tb_addsub_arbiter.sv
module tb_addsub_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  addsub_arbiter_if #(.NREQ(2), .IDW(1)) bus ();

  addsub_arbiter #(.NREQ(2), .IDW(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, need finish before 200000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_resp(input string tag, input logic id, input logic [63:0] out,
                            input logic zf, input logic sf, input logic of);
    chk({tag, ".valid"}, 64'(bus.resp_valid), 64'd1);
    chk({tag, ".id"},    64'(bus.resp_id),    64'(id));
    chk({tag, ".out"},   bus.resp_out,        out);
    chk({tag, ".zf"},    64'(bus.resp_zf),    64'(zf));
    chk({tag, ".sf"},    64'(bus.resp_sf),    64'(sf));
    chk({tag, ".of"},    64'(bus.resp_of),    64'(of));
  endtask

  // Present one operation on requester r for a single accepted cycle.
  task automatic do_op(input string tag, input int r, input logic [63:0] a,
                       input logic [63:0] b, input logic op);
    bus.req_valid          = 2'b00;
    bus.req_valid[r]       = 1'b1;
    bus.req_in1[r*64 +: 64] = a;
    bus.req_in2[r*64 +: 64] = b;
    bus.req_op[r]          = op;
    #1;
    chk({tag, ".ready"}, 64'(bus.req_ready), (r == 0) ? 64'd1 : 64'd2);
    tick();
    bus.req_valid = 2'b00;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.req_valid  = '0;
    bus.req_in1    = '0;
    bus.req_in2    = '0;
    bus.req_op     = '0;
    bus.resp_ready = 1'b1;
    tick();
    tick();
    chk("rst.valid", 64'(bus.resp_valid), 64'd0);
    chk("rst.out",   bus.resp_out,        64'd0);
    chk("rst.ready", 64'(bus.req_ready),  64'd0);
    rst = 1'b0;
    tick();

    do_op("add5p7", 1, 64'd5, 64'd7, 1'b0);
    check_resp("add5p7", 1'b1, 64'd12, 1'b0, 1'b0, 1'b0);
    tick();
    chk("drain.valid", 64'(bus.resp_valid), 64'd0);

    do_op("sub3m3", 0, 64'd3, 64'd3, 1'b1);
    check_resp("sub3m3", 1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    do_op("sub2m5", 0, 64'd2, 64'd5, 1'b1);
    check_resp("sub2m5", 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b1, 1'b0);
    do_op("subminm1", 0, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
    check_resp("subminm1", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
    do_op("addmaxp1", 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    check_resp("addmaxp1", 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
    do_op("addwrap", 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    check_resp("addwrap", 1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    do_op("sub0mmin", 1, 64'd0, 64'h8000_0000_0000_0000, 1'b1);
    check_resp("sub0mmin", 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);

    // Contention: requester 0 computes 10+1, requester 1 computes 100-50.
    bus.req_in1 = {64'd100, 64'd10};
    bus.req_in2 = {64'd50, 64'd1};
    bus.req_op  = 2'b10;
    bus.req_valid = 2'b11;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("rr%0d.ready", c), 64'(bus.req_ready), (c % 2 == 0) ? 64'd1 : 64'd2);
      tick();
      if (c % 2 == 0) check_resp($sformatf("rr%0d", c), 1'b0, 64'd11, 1'b0, 1'b0, 1'b0);
      else            check_resp($sformatf("rr%0d", c), 1'b1, 64'd50, 1'b0, 1'b0, 1'b0);
    end

    // Backpressure with the response register full (id 1, value 50).
    bus.req_valid  = 2'b01;
    bus.resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d.ready", c), 64'(bus.req_ready), 64'd0);
      tick();
      check_resp($sformatf("bp%0d", c), 1'b1, 64'd50, 1'b0, 1'b0, 1'b0);
    end
    bus.resp_ready = 1'b1;
    #1;
    chk("bprel.ready", 64'(bus.req_ready), 64'd1);
    tick();
    check_resp("bprel", 1'b0, 64'd11, 1'b0, 1'b0, 1'b0);
    bus.req_valid = 2'b00;

    // Async reset while a response is held; pointer currently sits at 1.
    #2;
    rst = 1'b1;
    #1;
    chk("arst.valid", 64'(bus.resp_valid), 64'd0);
    chk("arst.out",   bus.resp_out,        64'd0);
    chk("arst.id",    64'(bus.resp_id),    64'd0);
    tick();
    rst = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    chk("postrst.ready", 64'(bus.req_ready), 64'd1);
    tick();
    check_resp("postrst", 1'b0, 64'd11, 1'b0, 1'b0, 1'b0);
    bus.req_valid = 2'b00;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
